// File: rtl/fact_accel_if.sv
// Data-memory bus slice between the MIPS address decoder and the factorial
// accelerator: decoded write strobe, word select, write data, read data, busy.
interface fact_accel_if;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        busy;

  modport master (output we, a, wd, input  rd, busy);
  modport slave  (input  we, a, wd, output rd, busy);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: one 32x4 multiply per cycle.
// Define FACT_ERR_EN to flag n>12 as an error (result 0) instead of wrapping mod 2^32.
module fact_accel (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    A_N      = 2'd0,
    A_GO     = 2'd1,
    A_STATUS = 2'd2,
    A_RESULT = 2'd3
  } addr_e;

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic        go_q, go_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        wr_n;
  logic        wr_go;
  logic        start;
  logic [31:0] prod_mul;

  assign wr_n     = bus.we && (bus.a == A_N);
  assign wr_go    = bus.we && (bus.a == A_GO);
  assign start    = wr_go && bus.wd[0] && ((state_q == IDLE) || (state_q == DONE));
  assign prod_mul = prod_q * {28'd0, cnt_q};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d  = state_q;
    n_d      = n_q;
    go_d     = go_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    // Register writes land in any state; only a start from IDLE/DONE reaches the FSM.
    if (wr_n)  n_d  = bus.wd[3:0];
    if (wr_go) go_d = bus.wd[0];

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        // The operand is captured from n_q here; later N writes only change the register.
        cnt_d  = n_q;
        prod_d = 32'd1;
`ifdef FACT_ERR_EN
        if (n_q > 4'd12) begin
          err_d    = 1'b1;
          done_d   = 1'b1;
          result_d = 32'd0;
          state_d  = DONE;
        end else begin
          state_d  = CALC;
        end
`else
        state_d = CALC;
`endif
      end
      CALC: begin
        if (cnt_q > 4'd1) begin
          prod_d = prod_mul;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          result_d = prod_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= 4'd0;
      go_q     <= 1'b0;
      cnt_q    <= 4'd0;
      prod_q   <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      go_q     <= go_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    bus.rd = 32'd0;
    unique case (bus.a)
      A_N:      bus.rd = {28'd0, n_q};
      A_GO:     bus.rd = {31'd0, go_q};
      A_STATUS: bus.rd = {30'd0, err_q, done_q};
      A_RESULT: bus.rd = result_q;
      default:  bus.rd = 32'd0;
    endcase
  end

  assign bus.busy = (state_q == LOAD) || (state_q == CALC);

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel: the driver queues expected {busy, rd} per read,
// a separate monitor pops and compares each one against the live bus.
module tb_fact_accel;

  localparam logic [1:0] A_N      = 2'd0;
  localparam logic [1:0] A_GO     = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

`ifdef FACT_ERR_EN
  localparam logic [31:0] RES13 = 32'h0000_0000;
`else
  localparam logic [31:0] RES13 = 32'h7328_CC00;
`endif

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  event mon_ev;

  fact_accel_if bus ();

  fact_accel dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  // Monitor: one expected entry per read request, sampled 1 time unit after the request.
  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: read seen with empty scoreboard, busy=%0b rd=0x%08h", bus.busy, bus.rd);
      end else begin
        e = sb.pop_front();
        if ({bus.busy, bus.rd} !== {e.busy, e.rd}) begin
          n_fail++;
          $display("FAIL %s: got busy=%0b rd=0x%08h, expected busy=%0b rd=0x%08h",
                   e.name, bus.busy, bus.rd, e.busy, e.rd);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.wd = 32'd0;
  endtask

  // At most four reads between clock edges (each takes 2 time units, half period is 10).
  task automatic chk(input logic [1:0] addr, input logic [31:0] exp_rd,
                     input logic exp_busy, input string name);
    exp_t e;
    e.name = name;
    e.rd   = exp_rd;
    e.busy = exp_busy;
    sb.push_back(e);
    bus.we = 1'b0;
    bus.a  = addr;
    -> mon_ev;
    #2;
  endtask

  task automatic start_run(input logic [3:0] n);
    wr(A_N, {28'd0, n});
    wr(A_GO, 32'd1);
  endtask

  initial begin
    bus.we = 1'b0;
    bus.a  = 2'd0;
    bus.wd = 32'd0;

    // Reset held for two edges.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    chk(A_N,      32'd0, 1'b0, "reset_n");
    chk(A_GO,     32'd0, 1'b0, "reset_go");
    chk(A_STATUS, 32'd0, 1'b0, "reset_status");
    chk(A_RESULT, 32'd0, 1'b0, "reset_result");

    // Basic run, n=5: busy after edges 0..5, done after edge 6.
    wr(A_N, 32'd5);
    chk(A_N, 32'd5, 1'b0, "n5_readback");
    wr(A_GO, 32'd1);
    chk(A_GO,     32'd1, 1'b1, "n5_go_readback");
    chk(A_STATUS, 32'd0, 1'b1, "n5_edge0_status");
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk(A_STATUS, 32'd0, 1'b1, $sformatf("n5_edge%0d_busy", i));
    end
    chk(A_RESULT, 32'd0, 1'b1, "n5_edge5_result_old");
    tick(1);
    chk(A_STATUS, 32'd1,  1'b0, "n5_edge6_status");
    chk(A_RESULT, 32'h78, 1'b0, "n5_edge6_result");

    // n=0 and n=1 both complete after edge 2 with result 1.
    start_run(4'd0);
    tick(1);
    chk(A_RESULT, 32'h78, 1'b1, "n0_edge1_result_old");
    tick(1);
    chk(A_STATUS, 32'd1, 1'b0, "n0_edge2_status");
    chk(A_RESULT, 32'd1, 1'b0, "n0_edge2_result");

    start_run(4'd1);
    tick(1);
    chk(A_STATUS, 32'd0, 1'b1, "n1_edge1_status");
    tick(1);
    chk(A_STATUS, 32'd1, 1'b0, "n1_edge2_status");
    chk(A_RESULT, 32'd1, 1'b0, "n1_edge2_result");

    // n=12: largest exact 32-bit factorial, done after edge 13.
    start_run(4'd12);
    tick(12);
    chk(A_STATUS, 32'd0, 1'b1, "n12_edge12_status");
    tick(1);
    chk(A_STATUS, 32'd1,          1'b0, "n12_edge13_status");
    chk(A_RESULT, 32'h1C8C_FC00,  1'b0, "n12_edge13_result");

    // n=13: error flag with FACT_ERR_EN, otherwise wraps modulo 2^32.
    start_run(4'd13);
    tick(1);
`ifdef FACT_ERR_EN
    chk(A_STATUS, 32'd3, 1'b0, "n13_err_status");
    chk(A_RESULT, 32'd0, 1'b0, "n13_err_result");
`else
    chk(A_STATUS, 32'd0, 1'b1, "n13_edge1_status");
    tick(12);
    chk(A_RESULT, 32'h1C8C_FC00, 1'b1, "n13_edge13_result_old");
    tick(1);
    chk(A_STATUS, 32'd1, 1'b0, "n13_edge14_status");
    chk(A_RESULT, RES13, 1'b0, "n13_edge14_result");
`endif

    // Interference: N=3 at edge 2 and GO=1 at edge 3 must not disturb the n=5 run.
    start_run(4'd5);
    chk(A_STATUS, 32'd0, 1'b1, "intf_edge0_status");
    tick(1);
    wr(A_N, 32'd3);
    wr(A_GO, 32'd1);
    chk(A_N, 32'd3, 1'b1, "intf_edge3_n");
    tick(2);
    chk(A_RESULT, RES13, 1'b1, "intf_edge5_result_old");
    tick(1);
    chk(A_STATUS, 32'd1,  1'b0, "intf_edge6_status");
    chk(A_RESULT, 32'h78, 1'b0, "intf_edge6_result");

    // GO from DONE with n=3: done clears at once, result 6 after edge 4.
    wr(A_GO, 32'd1);
    chk(A_STATUS, 32'd0,  1'b1, "go_done_edge0_status");
    chk(A_RESULT, 32'h78, 1'b1, "go_done_edge0_result_old");
    tick(3);
    chk(A_STATUS, 32'd0, 1'b1, "go_done_edge3_status");
    tick(1);
    chk(A_STATUS, 32'd1, 1'b0, "go_done_edge4_status");
    chk(A_RESULT, 32'd6, 1'b0, "go_done_edge4_result");

    // Reset sampled at edge 4 of an n=10 run aborts it completely.
    start_run(4'd10);
    tick(3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk(A_N,      32'd0, 1'b0, "midrst_n");
    chk(A_GO,     32'd0, 1'b0, "midrst_go");
    chk(A_STATUS, 32'd0, 1'b0, "midrst_status");
    chk(A_RESULT, 32'd0, 1'b0, "midrst_result");
    tick(1);
    chk(A_STATUS, 32'd0, 1'b0, "midrst_stays_idle");

    start_run(4'd4);
    tick(4);
    chk(A_STATUS, 32'd0, 1'b1, "n4_edge4_status");
    tick(1);
    chk(A_STATUS, 32'd1,  1'b0, "n4_edge5_status");
    chk(A_RESULT, 32'h18, 1'b0, "n4_edge5_result");

    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
